// File: rtl/zap_wb_wbuf_drain.sv
// rtl/zap_wb_wbuf_drain.sv - drains the posted-write FIFO onto Wishbone B3 classic single writes
// Sticky ERR/timeout status with fault address; o_idle gates memory barriers in the core.
module zap_wb_wbuf_drain #(
    parameter int TIMEOUT = 256,
    parameter int TMR_WDT = 9
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [67:0] i_fifo_data,
    input  logic        i_fifo_empty_n,
    output logic        o_fifo_ack,
    input  logic        i_hold,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_err,
    output logic        o_timeout,
    output logic [31:0] o_fault_adr,
    input  logic        i_fault_clr,
    output logic        o_idle
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUS  = 1'b1;

    localparam logic               TMO_EN   = (TIMEOUT != 0);
    localparam logic [TMR_WDT-1:0] TMR_LAST = TMO_EN ? TMR_WDT'(TIMEOUT - 1) : '0;
    localparam logic [TMR_WDT-1:0] TMR_MAX  = '1;

    logic [0:0]         state;
    logic [TMR_WDT-1:0] timer;

    logic in_bus;
    logic can_issue;
    logic bus_ack;
    logic bus_err;
    logic bus_tmo;
    logic pop;

    assign in_bus    = (state == S_BUS);
    assign can_issue = i_fifo_empty_n && !i_hold;
    assign bus_ack   = in_bus && i_wb_ack;
    assign bus_err   = in_bus && !i_wb_ack && i_wb_err;
    assign bus_tmo   = in_bus && !i_wb_ack && !i_wb_err && TMO_EN && (timer == TMR_LAST);

    // A pop either starts a transfer from IDLE or chains onto an ACKed one.
    assign pop = i_reset_n && can_issue && (!in_bus || i_wb_ack);

    assign o_fifo_ack = pop;
    assign o_wb_cyc   = in_bus;
    assign o_wb_stb   = in_bus;
    assign o_wb_we    = in_bus;
    assign o_wb_cti   = 3'b000;
    assign o_idle     = (state == S_IDLE) && !i_fifo_empty_n;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
            o_err       <= 1'b0;
            o_timeout   <= 1'b0;
            o_fault_adr <= '0;
        end else begin
            if (pop) begin
                state    <= S_BUS;
                timer    <= '0;
                o_wb_sel <= i_fifo_data[67:64];
                o_wb_adr <= i_fifo_data[63:32];
                o_wb_dat <= i_fifo_data[31:0];
            end else if (bus_ack || bus_err || bus_tmo) begin
                state <= S_IDLE;
                timer <= '0;
            end else if (in_bus && (timer != TMR_MAX)) begin
                timer <= timer + 1'b1;
            end

            // Setting the sticky takes priority over a simultaneous clear.
            if (bus_err) begin
                o_err <= 1'b1;
            end else if (i_fault_clr) begin
                o_err <= 1'b0;
            end

            if (bus_tmo) begin
                o_timeout <= 1'b1;
            end else if (i_fault_clr) begin
                o_timeout <= 1'b0;
            end

            if (bus_err || bus_tmo) begin
                o_fault_adr <= o_wb_adr;
            end
        end
    end

endmodule

// File: tb/tb_zap_wb_wbuf_drain.sv
// tb/tb_zap_wb_wbuf_drain.sv - directed per-cycle vectors for zap_wb_wbuf_drain
module tb_zap_wb_wbuf_drain;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [67:0] i_fifo_data;
    logic        i_fifo_empty_n;
    logic        o_fifo_ack;
    logic        i_hold;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [2:0]  o_wb_cti;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic        o_err;
    logic        o_timeout;
    logic [31:0] o_fault_adr;
    logic        i_fault_clr;
    logic        o_idle;

    always #5 i_clk = ~i_clk;

    zap_wb_wbuf_drain #(.TIMEOUT(8), .TMR_WDT(4)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_fifo_data   (i_fifo_data),
        .i_fifo_empty_n(i_fifo_empty_n),
        .o_fifo_ack    (o_fifo_ack),
        .i_hold        (i_hold),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_adr      (o_wb_adr),
        .o_wb_dat      (o_wb_dat),
        .o_wb_sel      (o_wb_sel),
        .o_wb_cti      (o_wb_cti),
        .i_wb_ack      (i_wb_ack),
        .i_wb_err      (i_wb_err),
        .o_err         (o_err),
        .o_timeout     (o_timeout),
        .o_fault_adr   (o_fault_adr),
        .i_fault_clr   (i_fault_clr),
        .o_idle        (o_idle)
    );

    typedef struct {
        logic        rst_n;
        logic        emp_n;
        logic [67:0] data;
        logic        hold;
        logic        ack;
        logic        err;
        logic        clr;
        logic        x_pop;
        logic        x_cyc;
        logic [67:0] x_ent;
        logic        x_err;
        logic        x_tmo;
        logic [31:0] x_fadr;
        logic        x_idle;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    localparam logic [67:0] Z  = 68'h0;
    localparam logic [67:0] E1 = {4'hF, 32'h0000_1000, 32'hDEAD_BEEF};

    function automatic logic [67:0] ent(input logic [31:0] a);
        return {a[5:2] ^ 4'hA, a, ~a};
    endfunction

    task automatic add(input logic r, input logic e, input logic [67:0] d, input logic h,
                       input logic a, input logic er, input logic c,
                       input logic xp, input logic xc, input logic [67:0] xe,
                       input logic xr, input logic xt, input logic [31:0] xf, input logic xi);
        vec_t v;
        v.rst_n = r;  v.emp_n = e;  v.data = d;  v.hold = h;
        v.ack = a;    v.err = er;   v.clr = c;
        v.x_pop = xp; v.x_cyc = xc; v.x_ent = xe; v.x_err = xr;
        v.x_tmo = xt; v.x_fadr = xf; v.x_idle = xi;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge i_clk) if (o_fifo_ack === 1'b1) pops++;

    initial begin
        int n;
        i_reset_n = 1'b0; i_fifo_empty_n = 1'b0; i_fifo_data = Z; i_hold = 1'b0;
        i_wb_ack = 1'b0;  i_wb_err = 1'b0;       i_fault_clr = 1'b0;

        // single write, ACK on the third STB cycle
        add(1,1,E1,0,0,0,0, 1,0,Z,0,0,32'h0,0);
        add(1,0,Z,0,0,0,0, 0,1,E1,0,0,32'h0,0);
        add(1,0,Z,0,0,0,0, 0,1,E1,0,0,32'h0,0);
        add(1,0,Z,0,1,0,0, 0,1,E1,0,0,32'h0,0);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h0,1);
        // four back-to-back writes, zero-wait ACK
        add(1,1,ent(32'h2000),0,1,0,0, 1,0,Z,0,0,32'h0,0);
        add(1,1,ent(32'h2004),0,1,0,0, 1,1,ent(32'h2000),0,0,32'h0,0);
        add(1,1,ent(32'h2008),0,1,0,0, 1,1,ent(32'h2004),0,0,32'h0,0);
        add(1,1,ent(32'h200C),0,1,0,0, 1,1,ent(32'h2008),0,0,32'h0,0);
        add(1,0,Z,0,1,0,0, 0,1,ent(32'h200C),0,0,32'h0,0);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h0,1);
        // ERR on the second of three writes, dead cycle, then clear
        add(1,1,ent(32'h3000),0,0,0,0, 1,0,Z,0,0,32'h0,0);
        add(1,1,ent(32'h3004),0,1,0,0, 1,1,ent(32'h3000),0,0,32'h0,0);
        add(1,1,ent(32'h3008),0,0,1,0, 0,1,ent(32'h3004),0,0,32'h0,0);
        add(1,1,ent(32'h3008),0,0,0,0, 1,0,Z,1,0,32'h3004,0);
        add(1,0,Z,0,1,0,0, 0,1,ent(32'h3008),1,0,32'h3004,0);
        add(1,0,Z,0,0,0,1, 0,0,Z,1,0,32'h3004,1);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h3004,1);
        // silent slave: 8 STB cycles then timeout, late ACK ignored
        add(1,1,ent(32'h4000),0,0,0,0, 1,0,Z,0,0,32'h3004,0);
        for (int k = 0; k < 8; k++) add(1,0,Z,0,0,0,0, 0,1,ent(32'h4000),0,0,32'h3004,0);
        add(1,0,Z,0,1,0,0, 0,0,Z,0,1,32'h4000,1);
        add(1,0,Z,0,0,0,1, 0,0,Z,0,1,32'h4000,1);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h4000,1);
        // hold before and during a transfer
        add(1,1,ent(32'h5000),1,0,0,0, 0,0,Z,0,0,32'h4000,0);
        add(1,1,ent(32'h5000),1,0,0,0, 0,0,Z,0,0,32'h4000,0);
        add(1,1,ent(32'h5000),0,0,0,0, 1,0,Z,0,0,32'h4000,0);
        add(1,1,ent(32'h5004),0,1,0,0, 1,1,ent(32'h5000),0,0,32'h4000,0);
        add(1,1,ent(32'h5008),1,0,0,0, 0,1,ent(32'h5004),0,0,32'h4000,0);
        add(1,1,ent(32'h5008),1,1,0,0, 0,1,ent(32'h5004),0,0,32'h4000,0);
        add(1,1,ent(32'h5008),1,0,0,0, 0,0,Z,0,0,32'h4000,0);
        add(1,1,ent(32'h5008),0,0,0,0, 1,0,Z,0,0,32'h4000,0);
        add(1,0,Z,0,1,0,0, 0,1,ent(32'h5008),0,0,32'h4000,0);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h4000,1);
        // ERR with simultaneous clear: set wins
        add(1,1,ent(32'h6000),0,0,0,0, 1,0,Z,0,0,32'h4000,0);
        add(1,0,Z,0,0,1,1, 0,1,ent(32'h6000),0,0,32'h4000,0);
        add(1,0,Z,0,0,0,0, 0,0,Z,1,0,32'h6000,1);
        // reset while STB waits; ACK+head present during reset must not pop
        add(1,1,ent(32'h7000),0,0,0,0, 1,0,Z,1,0,32'h6000,0);
        add(1,0,Z,0,0,0,0, 0,1,ent(32'h7000),1,0,32'h6000,0);
        add(0,1,ent(32'h7000),0,1,0,0, 0,1,ent(32'h7000),1,0,32'h6000,0);
        add(1,1,ent(32'h7000),0,1,0,0, 1,0,Z,0,0,32'h0,0);
        add(1,0,Z,0,1,0,0, 0,1,ent(32'h7000),0,0,32'h0,0);
        add(1,0,Z,0,0,0,0, 0,0,Z,0,0,32'h0,1);

        repeat (2) @(negedge i_clk);
        #1;
        chk("rst cyc", o_wb_cyc, 0);
        chk("rst stb", o_wb_stb, 0);
        chk("rst we", o_wb_we, 0);
        chk("rst adr", o_wb_adr, 0);
        chk("rst dat", o_wb_dat, 0);
        chk("rst sel", o_wb_sel, 0);
        chk("rst err", o_err, 0);
        chk("rst tmo", o_timeout, 0);
        chk("rst fadr", o_fault_adr, 0);
        chk("rst pop", o_fifo_ack, 0);
        chk("rst idle", o_idle, 1);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge i_clk);
            i_reset_n = vt[i].rst_n; i_fifo_empty_n = vt[i].emp_n; i_fifo_data = vt[i].data;
            i_hold = vt[i].hold; i_wb_ack = vt[i].ack; i_wb_err = vt[i].err;
            i_fault_clr = vt[i].clr;
            #1;
            chk($sformatf("v%0d pop", i), o_fifo_ack, vt[i].x_pop);
            chk($sformatf("v%0d cyc", i), o_wb_cyc, vt[i].x_cyc);
            chk($sformatf("v%0d stb", i), o_wb_stb, vt[i].x_cyc);
            chk($sformatf("v%0d we", i), o_wb_we, vt[i].x_cyc);
            chk($sformatf("v%0d cti", i), o_wb_cti, 0);
            chk($sformatf("v%0d err", i), o_err, vt[i].x_err);
            chk($sformatf("v%0d tmo", i), o_timeout, vt[i].x_tmo);
            chk($sformatf("v%0d fadr", i), o_fault_adr, vt[i].x_fadr);
            chk($sformatf("v%0d idle", i), o_idle, vt[i].x_idle);
            if (vt[i].x_cyc) begin
                chk($sformatf("v%0d sel", i), o_wb_sel, vt[i].x_ent[67:64]);
                chk($sformatf("v%0d adr", i), o_wb_adr, vt[i].x_ent[63:32]);
                chk($sformatf("v%0d dat", i), o_wb_dat, vt[i].x_ent[31:0]);
            end
        end

        // ACK on the 8th STB cycle beats timeout; chained transfer gets a fresh 8-cycle window
        @(negedge i_clk);
        i_reset_n = 1'b1; i_fifo_empty_n = 1'b1; i_fifo_data = ent(32'h8000);
        i_hold = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_fault_clr = 1'b0;
        #1 chk("hs pop0", o_fifo_ack, 1);
        @(negedge i_clk);
        i_fifo_empty_n = 1'b0;
        #1 chk("hs adr0", o_wb_adr, 32'h8000);
        repeat (7) @(negedge i_clk);
        i_wb_ack = 1'b1; i_fifo_empty_n = 1'b1; i_fifo_data = ent(32'h8004);
        #1 chk("hs pop1", o_fifo_ack, 1);
        chk("hs cyc8", o_wb_cyc, 1);
        @(negedge i_clk);
        i_wb_ack = 1'b0; i_fifo_empty_n = 1'b0;
        #1 chk("hs adr1", o_wb_adr, 32'h8004);
        chk("hs tmo0", o_timeout, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!o_wb_cyc) break;
            n++;
            @(negedge i_clk);
            #1;
        end
        chk("hs stb cycles", n, 8);
        chk("hs tmo1", o_timeout, 1);
        chk("hs fadr", o_fault_adr, 32'h8004);
        chk("hs idle", o_idle, 1);
        chk("pop count", pops, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
